cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  32  minuend operand; latched when start is accepted.
REQ-006 b  input  32  subtrahend operand; latched when start is accepted.
REQ-007 op  input  3  set-condition select; latched when start is accepted.
REQ-008 busy  output  1  high while a compare is in progress.
REQ-009 done  output  1  one-cycle pulse marking that result and flags are valid.
REQ-010 result  output  32  set-condition word: {31'b0, cond}.
REQ-011 zf  output  1  difference equals zero.
REQ-012 nz  output  1  difference is non-zero.
REQ-013 sf  output  1  bit 31 of the difference.

Function
REQ-014 The block SHALL compute diff = a + ~b + 1 nibble-serially: 4 bits per cycle, LSB nibble first, 8 cycles total, carry held in a register between nibbles.
REQ-015 States: IDLE and RUN; a 3-bit nibble counter SHALL count 0..7 in RUN.
REQ-016 IDLE -> RUN on an edge with start=1: latch a, b and op, clear the counter, set carry=1, set the zero accumulator=1, set busy=1.
REQ-017 RUN: each edge processes nibble[counter], ANDs the zero accumulator with (nibble sum == 0), and increments the counter.
REQ-018 RUN -> IDLE on the edge that processes nibble 7; that same edge SHALL clear busy, set done=1, and register zf, nz=~zf, sf and result.
REQ-019 Latency: done SHALL rise exactly 8 edges after the edge that accepted start, and SHALL be high for exactly one cycle.
REQ-020 start while busy=1 SHALL be ignored; the latched operands SHALL be unaffected.
REQ-021 start=1 in the done cycle SHALL be accepted, giving back-to-back operation with a throughput of one compare per 8 cycles.
REQ-022 result, zf, nz and sf SHALL hold their values from the last completion until the next completion.
REQ-023 lt = sf. The sf-vs-overflow rule is governed by REQ-030 and REQ-031.
REQ-024 cond by op:
- 000 slt: lt
- 001 seq: zf
- 010 sne: nz
- 011 sgt: nz & ~lt
- 100 sle: zf | lt
- 101 sge: ~lt
- 110, 111: 0
REQ-025 result[31:1] SHALL be 0 for every op.
REQ-026 diff SHALL wrap modulo 2^32; the final carry-out SHALL be discarded.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, zf=0, nz=0, sf=0, counter=0 and carry=0.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for the aborted compare.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With OVF_CORRECT_EN defined: lt = sf ^ ovf, where ovf = (a[31] != b[31]) & (sf != a[31]), using the latched a and b. This gives a true signed compare.
REQ-031 With OVF_CORRECT_EN undefined: lt = sf (raw sign of the difference), and no ovf logic SHALL be synthesized.

Verification
REQ-032 a=5, b=5, op=001 -> done 8 edges after start; result=0x00000001, zf=1, nz=0, sf=0.
REQ-033 a=3, b=7, op=000 -> result=1, sf=1. Then a=7, b=3, op=011 issued in the done cycle -> accepted; result=1 after a further 8 edges.
REQ-034 a=0x7FFFFFFF, b=0xFFFFFFFF, op=000 -> sf=1. Without OVF_CORRECT_EN: result=1. With OVF_CORRECT_EN: result=0.
REQ-035 start a=1, b=2; pulse rst_n low 4 cycles later -> busy=0 and all outputs 0 at once; no done pulse.
REQ-036 start a=9, b=9, op=100; on the 3rd RUN cycle, start a=0, b=1 -> the second request is ignored; result=1 and zf=1.
REQ-037 a=0, b=0, op=110 -> result=0, zf=1; done width is exactly 1 cycle.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Nibble-serial 32-bit subtract (a - b) producing set-condition result and zf/nz/sf flags.
// Optional macro OVF_CORRECT_EN: when defined, lt uses signed-overflow correction (true signed compare).
module cond_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zf,
  output logic        nz,
  output logic        sf
);

  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned OPW = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0] LAST_NIB = CW'(7);

  logic [0:0]     state_q, state_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           zacc_q, zacc_d;
  logic           busy_d, done_d;
  logic [DW-1:0]  result_d;
  logic           zf_d, nz_d, sf_d;

  logic [NW-1:0]  nib_a, nib_b;
  logic [NW:0]    nib_sum;
  logic           fin_zf, fin_sf, lt, cond;

  // One nibble of a + ~b + carry per cycle
  assign nib_a   = a_q[{cnt_q, 2'b00} +: NW];
  assign nib_b   = b_q[{cnt_q, 2'b00} +: NW];
  assign nib_sum = {1'b0, nib_a} + {1'b0, ~nib_b} + {{NW{1'b0}}, carry_q};

  // Flag values as they stand once the top nibble has been added
  assign fin_zf = zacc_q & (nib_sum[NW-1:0] == {NW{1'b0}});
  assign fin_sf = nib_sum[NW-1];

`ifdef OVF_CORRECT_EN
  logic ovf;
  assign ovf = (a_q[DW-1] != b_q[DW-1]) & (fin_sf != a_q[DW-1]);
  assign lt  = fin_sf ^ ovf;
`else
  assign lt  = fin_sf;
`endif

  always_comb begin
    cond = 1'b0;
    case (op_q)
      3'b000:  cond = lt;
      3'b001:  cond = fin_zf;
      3'b010:  cond = ~fin_zf;
      3'b011:  cond = ~fin_zf & ~lt;
      3'b100:  cond = fin_zf | lt;
      3'b101:  cond = ~lt;
      default: cond = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    zf_d     = zf;
    nz_d     = nz;
    sf_d     = sf;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = 1'b1;
          zacc_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        carry_d = nib_sum[NW];
        zacc_d  = fin_zf;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_NIB) begin
          // Final carry-out is dropped: the difference wraps modulo 2^32
          state_d  = IDLE;
          carry_d  = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          zf_d     = fin_zf;
          nz_d     = ~fin_zf;
          sf_d     = fin_sf;
          result_d = {{(DW-1){1'b0}}, cond};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zf      <= 1'b0;
      nz      <= 1'b0;
      sf      <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      zf      <= zf_d;
      nz      <= nz_d;
      sf      <= sf_d;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomized self-checking bench for cond_flag_unit against a plain-arithmetic compare model.
module tb_cond_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zf;
  logic        nz;
  logic        sf;

  int n_tests;
  int n_fail;
  logic [3:0] last_exp;

  cond_flag_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zf     (zf),
    .nz     (nz),
    .sf     (sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {cond, zf, nz, sf} from the compare semantics directly
  function automatic logic [3:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] o);
    logic [31:0] diff;
    logic z, s, l, c;
    diff = x - y;
    z = (diff == 32'd0);
    s = diff[31];
`ifdef OVF_CORRECT_EN
    l = ($signed(x) < $signed(y));
`else
    l = s;
`endif
    case (o)
      3'd0:    c = l;
      3'd1:    c = z;
      3'd2:    c = !z;
      3'd3:    c = !z && !l;
      3'd4:    c = z || l;
      3'd5:    c = !l;
      default: c = 1'b0;
    endcase
    return {c, z, !z, s};
  endfunction

  task automatic check_outs(input string tag, input logic [3:0] e);
    check({tag, "_result"}, result, {31'd0, e[3]});
    check({tag, "_zf"}, {31'd0, zf}, {31'd0, e[2]});
    check({tag, "_nz"}, {31'd0, nz}, {31'd0, e[1]});
    check({tag, "_sf"}, {31'd0, sf}, {31'd0, e[0]});
  endtask

  // Issue one compare; inj>0 drives a spurious start during that RUN cycle.
  // Returns in the done cycle (#1 after the completing edge).
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] o, input int inj);
    int  lat;
    bit  got;
    logic [3:0] e;
    e = ref_model(x, y, o);
    a = x; b = y; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (inj > 0 && lat == inj - 1) begin
        start = 1'b1; a = 32'd0; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check_outs(tag, e);
    last_exp = e;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    end
    check_outs({tag, "_hold"}, last_exp);
  endtask

  initial begin
    int  seen;
    logic [31:0] x, y;
    n_tests  = 0;
    n_fail   = 0;
    last_exp = 4'd0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_outs("rst", 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First start right after reset release
    run_op("seq_eq", 32'd5, 32'd5, 3'b001, 0);
    check("seq_eq_val", result, 32'h1);
    idle_check("seq_eq", 2);

    // Back-to-back: second compare issued in the done cycle
    run_op("slt_3_7", 32'd3, 32'd7, 3'b000, 0);
    run_op("sgt_7_3", 32'd7, 32'd3, 3'b011, 0);
    idle_check("sgt", 1);

    run_op("slt_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b000, 0);
    idle_check("slt_ovf", 1);

    // Spurious start during RUN must be ignored
    run_op("sle_ign", 32'd9, 32'd9, 3'b100, 3);
    idle_check("sle_ign", 1);

    run_op("op110", 32'd0, 32'd0, 3'b110, 0);
    @(posedge clk); #1;
    check("op110_width", {31'd0, done}, 32'd0);

    // Abort mid-RUN with reset
    a = 32'd1; b = 32'd2; op = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check_outs("abort", 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    last_exp = 4'd0;

    // Random compares, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (32'h1 << $urandom_range(0, 31));
        default: y = $urandom;
      endcase
      run_op("rand", x, y, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 1) idle_check("rand", $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
